// File: rtl/nibble_gather.sv
// Gathers a serial 4-bit nibble stream into 12-bit {e,f,g} groups and queues
// them in a small FIFO that drives the downstream triplet inputs in parallel.
module nibble_gather #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_nib,
  input  logic             in_vld,
  input  logic             in_sof,
  output logic             in_rdy,
  output logic [3:0]       out_e,
  output logic [3:0]       out_f,
  output logic [3:0]       out_g,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             err_sof,
  output logic [CNT_W-1:0] fifo_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {G0, G1, G2} gather_t;

  gather_t       state, state_nxt;
  logic          acc, pop, push, load_e, load_f, discard;
  logic [3:0]    stage_e, stage_f;
  logic [11:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= G0;
    else        state <= state_nxt;
  end

  // A start-of-group nibble always restarts the gather at index 1.
  always_comb begin
    state_nxt = state;
    if (acc) begin
      if (in_sof) begin
        state_nxt = G1;
      end else begin
        case (state)
          G0:      state_nxt = G1;
          G1:      state_nxt = G2;
          default: state_nxt = G0;
        endcase
      end
    end
  end

  // Only the third nibble can stall: it needs a free FIFO slot.
  always_comb begin
    in_rdy  = (state != G2) || (fifo_cnt != FULL);
    acc     = in_vld && in_rdy;
    load_e  = acc && (in_sof || state == G0);
    load_f  = acc && !in_sof && state == G1;
    push    = acc && !in_sof && state == G2;
    discard = acc && in_sof && state != G0;
  end

  assign out_vld = (fifo_cnt != '0);
  assign pop     = out_vld && out_rdy;
  assign {out_e, out_f, out_g} = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_e  <= '0;
      stage_f  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      err_sof  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      err_sof <= discard;
      if (load_e) stage_e <= in_nib;
      if (load_f) stage_f <= in_nib;
      if (push) begin
        mem[wr_ptr] <= {stage_e, stage_f, in_nib};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end
endmodule
